// File: rtl/fetch_pc_sequencer.sv
// Next-PC select for fetch: fall-through, decode jump, execute mispredict, trap vector.
// nextpc is combinational (0 cycles); kill is registered (1 cycle after the redirect is sampled).
// Redirects seen while fetch cannot consume are held (highest rank wins) until a consume edge.
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        fetch_ready,
    input  logic [31:0] inst0_pc,
    input  logic        dec_redirect_valid,
    input  logic [31:0] dec_redirect_target,
    input  logic        ex_redirect_valid,
    input  logic [31:0] ex_redirect_target,
    input  logic        trap_valid,
    input  logic [31:0] trap_target,
    output logic [31:0] nextpc,
    output logic        kill,
    output logic        redirect_pending
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [1:0] RANK_NONE = 2'd0;
    localparam logic [1:0] RANK_DEC  = 2'd1;
    localparam logic [1:0] RANK_EX   = 2'd2;
    localparam logic [1:0] RANK_TRAP = 2'd3;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pend_target;
    logic [31:0] pend_target_nxt;
    logic [1:0]  pend_rank;
    logic [1:0]  pend_rank_nxt;
    logic [31:0] last_pc;

    logic        consume;
    logic        dec_ok;
    logic [1:0]  in_rank;
    logic [31:0] in_target;
    logic        in_valid;
    logic        use_in;
    logic [31:0] fall_pc;

    assign consume = fetch_ready & ~stall;

    // Decode redirects in a kill cycle come from flushed instructions.
    assign dec_ok = dec_redirect_valid & ~kill;

    always_comb begin
        in_rank   = RANK_NONE;
        in_target = 32'h0;
        if (trap_valid) begin
            in_rank   = RANK_TRAP;
            in_target = trap_target;
        end else if (ex_redirect_valid) begin
            in_rank   = RANK_EX;
            in_target = ex_redirect_target;
        end else if (dec_ok) begin
            in_rank   = RANK_DEC;
            in_target = dec_redirect_target;
        end
    end

    assign in_valid = (in_rank != RANK_NONE);
    assign use_in   = in_valid & ((state == IDLE) | (in_rank >= pend_rank));
    assign fall_pc  = (fetch_ready ? inst0_pc : last_pc) + 32'd4;

    always_comb begin
        nextpc = fall_pc;
        if (use_in) begin
            nextpc = {in_target[31:2], 2'b00};
        end else if (state == PEND) begin
            nextpc = pend_target;
        end
    end

    always_comb begin
        state_nxt       = state;
        pend_target_nxt = pend_target;
        pend_rank_nxt   = pend_rank;
        case (state)
            IDLE: begin
                if (in_valid && !consume) begin
                    state_nxt       = PEND;
                    pend_target_nxt = {in_target[31:2], 2'b00};
                    pend_rank_nxt   = in_rank;
                end
            end
            PEND: begin
                if (consume) begin
                    state_nxt     = IDLE;
                    pend_rank_nxt = RANK_NONE;
                end else if (use_in) begin
                    pend_target_nxt = {in_target[31:2], 2'b00};
                    pend_rank_nxt   = in_rank;
                end
            end
            default: begin
                state_nxt     = IDLE;
                pend_rank_nxt = RANK_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pend_target <= 32'h0;
            pend_rank   <= RANK_NONE;
            last_pc     <= RESET_PC;
            kill        <= 1'b0;
        end else begin
            state       <= state_nxt;
            pend_target <= pend_target_nxt;
            pend_rank   <= pend_rank_nxt;
            if (fetch_ready) begin
                last_pc <= inst0_pc;
            end
            kill        <= trap_valid | ex_redirect_valid;
        end
    end

    assign redirect_pending = (state == PEND);

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer; consume-edge nextpc values come from an expectation queue.
module tb_fetch_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        fetch_ready = 1'b0;
    logic [31:0] inst0_pc = 32'h0;
    logic        dec_redirect_valid = 1'b0;
    logic [31:0] dec_redirect_target = 32'h0;
    logic        ex_redirect_valid = 1'b0;
    logic [31:0] ex_redirect_target = 32'h0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_target = 32'h0;
    logic [31:0] nextpc;
    logic        kill;
    logic        redirect_pending;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    fetch_pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk                 (clk),
        .reset               (reset),
        .stall               (stall),
        .fetch_ready         (fetch_ready),
        .inst0_pc            (inst0_pc),
        .dec_redirect_valid  (dec_redirect_valid),
        .dec_redirect_target (dec_redirect_target),
        .ex_redirect_valid   (ex_redirect_valid),
        .ex_redirect_target  (ex_redirect_target),
        .trap_valid          (trap_valid),
        .trap_target         (trap_target),
        .nextpc              (nextpc),
        .kill                (kill),
        .redirect_pending    (redirect_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
    task automatic drive(input logic rst, input logic st, input logic fr, input logic [31:0] pc,
                         input logic dv, input logic [31:0] dt,
                         input logic ev, input logic [31:0] et,
                         input logic tv, input logic [31:0] tt);
        @(posedge clk);
        #1;
        reset = rst; stall = st; fetch_ready = fr; inst0_pc = pc;
        dec_redirect_valid = dv; dec_redirect_target = dt;
        ex_redirect_valid = ev; ex_redirect_target = et;
        trap_valid = tv; trap_target = tt;
        @(negedge clk);
    endtask

    task automatic idle(input logic st, input logic fr, input logic [31:0] pc);
        drive(1'b0, st, fr, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Scoreboard side: every consume edge must match the next queued nextpc.
    always @(negedge clk) begin
        if (!reset && fetch_ready && !stall) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_consume_qsize", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("consume_nextpc", nextpc, exp_q.pop_front());
            end
        end
    end

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1'b0, 1'b0, 32'h0);
        chk("reset_kill", 32'(kill), 32'd0);
        chk("reset_pending", 32'(redirect_pending), 32'd0);
        chk("reset_nextpc", nextpc, RST_PC + 32'd4);

        // Plain fall-through from the held instruction.
        exp_q.push_back(32'h104);
        idle(1'b0, 1'b1, 32'h100);
        chk("ft_kill", 32'(kill), 32'd0);
        chk("ft_pending", 32'(redirect_pending), 32'd0);

        // Execute redirect while fetch is not ready: held, then consumed.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 32'h0);
        chk("ex_comb_nextpc", nextpc, 32'h200);
        idle(1'b0, 1'b0, 32'h0);
        chk("ex_pending", 32'(redirect_pending), 32'd1);
        chk("ex_kill", 32'(kill), 32'd1);
        chk("ex_held_nextpc", nextpc, 32'h200);
        exp_q.push_back(32'h200);
        idle(1'b0, 1'b1, 32'h104);
        chk("ex_kill_one_cycle", 32'(kill), 32'd0);
        idle(1'b0, 1'b0, 32'h0);
        chk("ex_pending_cleared", 32'(redirect_pending), 32'd0);
        chk("ex_after_nextpc", nextpc, 32'h108);

        // All three redirects at a consume edge: trap wins, nothing held.
        exp_q.push_back(32'h80);
        drive(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h400, 1'b1, 32'h300, 1'b1, 32'h80);
        idle(1'b0, 1'b0, 32'h0);
        chk("all3_kill", 32'(kill), 32'd1);
        chk("all3_pending", 32'(redirect_pending), 32'd0);

        // Pending ex under stall: lower-rank dec ignored, trap upgrades.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 32'h0);
        idle(1'b1, 1'b1, 32'h200);
        chk("stall_pending", 32'(redirect_pending), 32'd1);
        chk("stall_kill", 32'(kill), 32'd1);
        drive(1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("dec_low_rank_nextpc", nextpc, 32'h300);
        chk("dec_no_kill_yet", 32'(kill), 32'd0);
        drive(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h80);
        chk("trap_upgrade_comb", nextpc, 32'h80);
        idle(1'b1, 1'b1, 32'h200);
        chk("trap_upgrade_kill", 32'(kill), 32'd1);
        chk("trap_upgrade_pending", 32'(redirect_pending), 32'd1);
        chk("trap_upgrade_held", nextpc, 32'h80);
        exp_q.push_back(32'h80);
        idle(1'b0, 1'b1, 32'h300);
        chk("release_kill", 32'(kill), 32'd0);
        idle(1'b0, 1'b0, 32'h0);
        chk("release_pending", 32'(redirect_pending), 32'd0);
        chk("release_ft", nextpc, 32'h304);

        // Fall-through wrap and target alignment.
        exp_q.push_back(32'h0);
        idle(1'b0, 1'b1, 32'hFFFF_FFFC);
        exp_q.push_back(32'h200);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h203, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1'b0, 1'b0, 32'h0);
        chk("dec_never_kills", 32'(kill), 32'd0);
        chk("dec_consumed_pending", 32'(redirect_pending), 32'd0);

        // Dec redirect during a kill cycle is dropped.
        exp_q.push_back(32'h600);
        drive(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h600, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("dec_in_kill_kill", 32'(kill), 32'd1);
        chk("dec_in_kill_nextpc", nextpc, 32'h14);
        idle(1'b0, 1'b0, 32'h0);
        chk("dec_in_kill_not_held", 32'(redirect_pending), 32'd0);

        // Equal-rank overwrite and back-to-back kill pulses.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h900, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hA00, 1'b0, 32'h0);
        chk("b2b_kill_first", 32'(kill), 32'd1);
        idle(1'b0, 1'b0, 32'h0);
        chk("b2b_kill_second", 32'(kill), 32'd1);
        chk("eq_rank_overwrite", nextpc, 32'hA00);
        idle(1'b0, 1'b0, 32'h0);
        chk("b2b_kill_end", 32'(kill), 32'd0);
        chk("eq_rank_still_pending", 32'(redirect_pending), 32'd1);

        // Reset drops the pending redirect and a simultaneous trap.
        drive(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h40);
        idle(1'b0, 1'b0, 32'h0);
        chk("rst2_pending", 32'(redirect_pending), 32'd0);
        chk("rst2_kill", 32'(kill), 32'd0);
        chk("rst2_nextpc", nextpc, RST_PC + 32'd4);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
